seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal 8..64, power of two).
REQ-002 The block SHALL have parameter ADDR_W, default 10, meaning RAM address width taken from the result (ADDR_W <= WIDTH).
REQ-003 The block SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  request valid.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port op  input  4  operation code per REQ-013.
REQ-008 The block SHALL have ports operand_a, operand_b  input  WIDTH  operands, sampled only at accept.
REQ-009 The block SHALL have port out_valid  output  1  result valid.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 The block SHALL have ports result  output  WIDTH, zero_flag  output  1, overflow  output  1, div_by_zero  output  1, ram_address  output  ADDR_W  (result[ADDR_W-1:0]).

Function
REQ-012 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; result delivery SHALL occur on an edge with out_valid=1 and out_ready=1.
REQ-013 Op codes SHALL be: 0000 ADD, 0001 SUB, 0010 ADDU, 0011 SUBU, 0100 AND, 0101 OR, 0110 XOR, 0111 NOR, 1000 SLL, 1001 SRL, 1010 SRA, 1011 SLT, 1100 SLTU, 1101 MULU (low WIDTH bits), 1110 DIVU (quotient), 1111 REMU (remainder).
REQ-014 All arithmetic SHALL be modulo 2^WIDTH two's complement; SUB/SUBU result = a - b exactly.
REQ-015 overflow SHALL be 1 only for ADD (a,b same sign, result sign differs) and SUB (a,b sign differ, result sign differs from a); 0 for all other ops.
REQ-016 Shifts SHALL use only operand_b[log2(WIDTH)-1:0] as amount; SRA SHALL replicate a[WIDTH-1].
REQ-017 SLT/SLTU SHALL return 1 or 0 zero-extended, signed/unsigned compare respectively.
REQ-018 zero_flag SHALL equal (result == 0) for the registered result.
REQ-019 The FSM SHALL have states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-020 IDLE SHALL go to DONE on accept of ops 0000-1100 (result valid one cycle after accept), and to BUSY on accept of 1101-1111.
REQ-021 BUSY SHALL iterate one bit per cycle (shift-add multiply, restoring divide) with a counter, entering DONE exactly WIDTH cycles after entering BUSY (out_valid WIDTH+1 cycles after accept).
REQ-022 DIVU/REMU with operand_b=0 SHALL skip BUSY: DONE next cycle, quotient all ones, remainder = operand_a, div_by_zero=1; div_by_zero SHALL be 0 otherwise.
REQ-023 DONE SHALL hold result and all flags stable while out_ready=0, and SHALL return to IDLE on delivery; a new accept SHALL not occur in that same cycle.
REQ-024 in_valid during BUSY/DONE SHALL be ignored without side effects.

Reset
REQ-025 With reset=0 at a rising edge, state SHALL become IDLE, counter 0, result 0, overflow 0, div_by_zero 0, out_valid 0; zero_flag therefore 1, in_ready 1 on the following cycle.
REQ-026 Reset asserted during BUSY or DONE SHALL abort the operation; the pending result SHALL never be delivered.

Configuration
REQ-027 Macro SEQ_ALU_MULDIV_EN SHALL, when defined, compile in the iterative multiply/divide datapath and BUSY state per REQ-020..022.
REQ-028 Without SEQ_ALU_MULDIV_EN, ops 1101-1111 SHALL complete in one cycle with result 0, overflow 0, div_by_zero 0, and BUSY SHALL be unreachable.

Verification
REQ-029 WIDTH=32 ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, out_valid one cycle after accept.
REQ-030 SUB 0x80000000-1 -> result 0x7FFFFFFF, overflow=1; SUBU same operands -> same result, overflow=0.
REQ-031 MULU 0x0001_0003 x 0x0000_0005 with macro -> result 0x0005_000F, out_valid exactly 33 cycles after accept.
REQ-032 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF, div_by_zero=1, one-cycle latency.
REQ-033 Hold out_ready=0 for 5 cycles after AND 0xF0F0/0x0FF0 -> result 0x00F0 stable, in_ready=0 throughout; delivery then in_ready=1 next cycle.
REQ-034 Assert reset=0 mid-MULU (cycle 10 of BUSY) -> IDLE, out_valid never asserted for that request, next ADD 2+3 -> 5.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready request/response handshake.
// Define SEQ_ALU_MULDIV_EN to build the iterative multiply/divide datapath and its BUSY state.
module seq_alu #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [WIDTH-1:0]  operand_a,
    input  logic [WIDTH-1:0]  operand_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero_flag,
    output logic              overflow,
    output logic              div_by_zero,
    output logic [ADDR_W-1:0] ram_address
);
    localparam int unsigned SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_ADDU = 4'h2;
    localparam logic [3:0] OP_SUBU = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOR  = 4'h7;
    localparam logic [3:0] OP_SLL  = 4'h8;
    localparam logic [3:0] OP_SRL  = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_SLT  = 4'hB;
    localparam logic [3:0] OP_SLTU = 4'hC;
    localparam logic [3:0] OP_MULU = 4'hD;
    localparam logic [3:0] OP_DIVU = 4'hE;
    localparam logic [3:0] OP_REMU = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_dbz;
    logic             slt_bit;
    logic             sltu_bit;

    assign sum      = operand_a + operand_b;
    assign diff     = operand_a - operand_b;
    assign shamt    = operand_b[SH_W-1:0];
    assign slt_bit  = $signed(operand_a) < $signed(operand_b);
    assign sltu_bit = operand_a < operand_b;

    assign ram_address = result[ADDR_W-1:0];

`ifdef SEQ_ALU_MULDIV_EN
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] count;
    logic [3:0]       md_op;
    logic [WIDTH-1:0] md_x;
    logic [WIDTH-1:0] md_y;
    logic [WIDTH-1:0] md_acc;
    logic [WIDTH-1:0] mul_acc_nxt;
    logic [WIDTH-1:0] div_rem_nxt;
    logic [WIDTH-1:0] div_quo_nxt;
    logic [WIDTH-1:0] md_res;
    logic [WIDTH:0]   trial;
    logic             b_zero;
    logic             start_md;

    assign b_zero   = (operand_b == '0);
    assign start_md = (op == OP_MULU) || (((op == OP_DIVU) || (op == OP_REMU)) && !b_zero);

    // md_x holds multiplicand/divisor, md_y multiplier/dividend-quotient, md_acc product/remainder.
    always_comb begin
        mul_acc_nxt = md_acc + (md_y[0] ? md_x : '0);
        trial       = {md_acc, md_y[WIDTH-1]} - {1'b0, md_x};
        div_rem_nxt = trial[WIDTH-1:0];
        div_quo_nxt = {md_y[WIDTH-2:0], 1'b1};
        md_res      = div_rem_nxt;
        if (trial[WIDTH]) begin
            div_rem_nxt = {md_acc[WIDTH-2:0], md_y[WIDTH-1]};
            div_quo_nxt = {md_y[WIDTH-2:0], 1'b0};
        end
        case (md_op)
            OP_MULU: md_res = mul_acc_nxt;
            OP_DIVU: md_res = div_quo_nxt;
            default: md_res = div_rem_nxt;
        endcase
    end
`endif

    // Single-cycle result; mul/div slots only resolve the divide-by-zero shortcut here.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_dbz = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUBU: alu_res = diff;
            OP_AND:  alu_res = operand_a & operand_b;
            OP_OR:   alu_res = operand_a | operand_b;
            OP_XOR:  alu_res = operand_a ^ operand_b;
            OP_NOR:  alu_res = ~(operand_a | operand_b);
            OP_SLL:  alu_res = operand_a << shamt;
            OP_SRL:  alu_res = operand_a >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(operand_a) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, sltu_bit};
`ifdef SEQ_ALU_MULDIV_EN
            OP_DIVU: begin
                alu_res = '1;
                alu_dbz = b_zero;
            end
            OP_REMU: begin
                alu_res = operand_a;
                alu_dbz = b_zero;
            end
`endif
            default: alu_res = '0;
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            result      <= '0;
            zero_flag   <= 1'b1;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
            count       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
                        if (start_md) begin
                            state  <= BUSY;
                            count  <= '0;
                            md_op  <= op;
                            md_x   <= operand_b;
                            md_y   <= operand_a;
                            md_acc <= '0;
                        end else
`endif
                        begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            result      <= alu_res;
                            zero_flag   <= (alu_res == '0);
                            overflow    <= alu_ovf;
                            div_by_zero <= alu_dbz;
                        end
                    end
                end
`ifdef SEQ_ALU_MULDIV_EN
                BUSY: begin
                    count <= count + CNT_W'(1);
                    if (md_op == OP_MULU) begin
                        md_acc <= mul_acc_nxt;
                        md_x   <= md_x << 1;
                        md_y   <= md_y >> 1;
                    end else begin
                        md_acc <= div_rem_nxt;
                        md_y   <= div_quo_nxt;
                    end
                    if (count == CNT_W'(WIDTH-1)) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        result      <= md_res;
                        zero_flag   <= (md_res == '0);
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=32): directed vectors, hold/stall, reset abort and random ops vs a reference model.
module tb_seq_alu;
    localparam int unsigned W = 32;
`ifdef SEQ_ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero_flag;
    logic         overflow;
    logic         div_by_zero;
    logic [9:0]   ram_address;

    int total = 0;
    int bad   = 0;

    seq_alu dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero_flag(zero_flag), .overflow(overflow),
        .div_by_zero(div_by_zero), .ram_address(ram_address)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ov;
        logic         dz;
        int           lat;
    } vec_t;

    // Reference: exact integer arithmetic, then truncate; overflow = truncated value lost information.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic ov, output logic dz,
                                  output int lat);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = longint'(a);
        longint unsigned ub = longint'(b);
        longint          s;
        logic [4:0]      sh = b[4:0];
        r = '0; ov = 1'b0; dz = 1'b0; lat = 1;
        case (o)
            4'h0: begin s = sa + sb; r = W'(s); ov = (s != longint'($signed(r))); end
            4'h1: begin s = sa - sb; r = W'(s); ov = (s != longint'($signed(r))); end
            4'h2: r = W'(ua + ub);
            4'h3: r = W'(ua - ub);
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = a ^ b;
            4'h7: r = ~(a | b);
            4'h8: r = W'(ua << sh);
            4'h9: r = W'(ua >> sh);
            4'hA: r = W'(sa >>> sh);
            4'hB: r = (sa < sb) ? 1 : 0;
            4'hC: r = (ua < ub) ? 1 : 0;
            default: begin
                if (MD) begin
                    if (o == 4'hD) begin r = W'(ua * ub); lat = W + 1; end
                    else if (b == 0) begin r = (o == 4'hE) ? '1 : a; dz = 1'b1; end
                    else begin r = (o == 4'hE) ? W'(ua / ub) : W'(ua % ub); lat = W + 1; end
                end
            end
        endcase
    endfunction

    // Issue one request from IDLE and wait (bounded) for out_valid; in_valid is noise while waiting.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic zf, output logic ov,
                          output logic dz, output int lat);
        op = o; operand_a = a; operand_b = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        while (!out_valid && lat < 100) begin
            in_valid = 1'($urandom_range(0, 1));
            op = 4'($urandom); operand_a = $urandom; operand_b = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        r = result; zf = zero_flag; ov = overflow; dz = div_by_zero;
    endtask

    task automatic deliver();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; operand_a = '0; operand_b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        total++; if (result !== '0) begin bad++; $display("FAIL reset_result got %h want 0", result); end
        total++; if (zero_flag !== 1'b1) begin bad++; $display("FAIL reset_zero_flag got %b want 1", zero_flag); end
        total++; if ({overflow, div_by_zero} !== 2'b00) begin bad++; $display("FAIL reset_flags got %b want 00", {overflow, div_by_zero}); end
        total++; if (ram_address !== '0) begin bad++; $display("FAIL reset_ram_address got %h want 0", ram_address); end
    endtask

    task automatic test_directed();
        vec_t         v[$];
        logic [W-1:0] r;
        logic         zf, ov, dz;
        int           lat;
        v.push_back('{4'h0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1, 1'b0, 1});
        v.push_back('{4'h1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b0, 1});
        v.push_back('{4'h3, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b0, 1});
        v.push_back('{4'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1});
        v.push_back('{4'hA, 32'h80000000, 32'h4, 32'hF8000000, 1'b0, 1'b0, 1});
        v.push_back('{4'h8, 32'h1, 32'h21, 32'h2, 1'b0, 1'b0, 1});
        v.push_back('{4'hB, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1});
        v.push_back('{4'hC, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1});
        v.push_back('{4'h7, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1});
        v.push_back('{4'hD, 32'h00010003, 32'h5, MD ? 32'h0005000F : 32'h0, 1'b0, 1'b0, MD ? 33 : 1});
        v.push_back('{4'hE, 32'd100, 32'd7, MD ? 32'd14 : 32'd0, 1'b0, 1'b0, MD ? 33 : 1});
        v.push_back('{4'hF, 32'd100, 32'd7, MD ? 32'd2 : 32'd0, 1'b0, 1'b0, MD ? 33 : 1});
        v.push_back('{4'hE, 32'd5, 32'd0, MD ? 32'hFFFFFFFF : 32'h0, 1'b0, MD, 1});
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, r, zf, ov, dz, lat);
            total++; if (r !== v[i].res) begin bad++; $display("FAIL dir%0d_result got %h want %h", i, r, v[i].res); end
            total++; if (ov !== v[i].ov) begin bad++; $display("FAIL dir%0d_overflow got %b want %b", i, ov, v[i].ov); end
            total++; if (dz !== v[i].dz) begin bad++; $display("FAIL dir%0d_div_by_zero got %b want %b", i, dz, v[i].dz); end
            total++; if (zf !== (v[i].res == 0)) begin bad++; $display("FAIL dir%0d_zero_flag got %b want %b", i, zf, v[i].res == 0); end
            total++; if (lat != v[i].lat) begin bad++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, v[i].lat); end
            deliver();
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] r;
        logic         zf, ov, dz;
        int           lat;
        run_op(4'h4, 32'hF0F0, 32'h0FF0, r, zf, ov, dz, lat);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; op = 4'($urandom); operand_a = $urandom;
            total++; if (result !== 32'h00F0) begin bad++; $display("FAIL hold%0d_result got %h want 000000f0", c, result); end
            total++; if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL hold%0d_handshake got %b want 10", c, {out_valid, in_ready}); end
            @(posedge clk); #1;
        end
        deliver();
        total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL hold_after_delivery got %b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, r, er;
        logic [3:0]   o;
        logic         zf, ov, dz, eov, edz;
        int           lat, elat;
        for (int n = 0; n < 150; n++) begin
            o = 4'($urandom);
            case ($urandom_range(0, 3))
                0: a = 32'h80000000;
                1: a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: b = '0;
                1: b = 32'h7FFFFFFF;
                2: b = 32'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            model(o, a, b, er, eov, edz, elat);
            run_op(o, a, b, r, zf, ov, dz, lat);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            total++; if (lat != elat) begin bad++; $display("FAIL rnd%0d_latency op=%h got %0d want %0d", n, o, lat, elat); end
            total++; if (result !== er) begin bad++; $display("FAIL rnd%0d_result op=%h a=%h b=%h got %h want %h", n, o, a, b, result, er); end
            total++; if ({overflow, div_by_zero} !== {eov, edz}) begin bad++; $display("FAIL rnd%0d_flags op=%h got %b want %b", n, o, {overflow, div_by_zero}, {eov, edz}); end
            total++; if (zero_flag !== (er == 0)) begin bad++; $display("FAIL rnd%0d_zero_flag got %b want %b", n, zero_flag, er == 0); end
            total++; if (ram_address !== er[9:0]) begin bad++; $display("FAIL rnd%0d_ram_address got %h want %h", n, ram_address, er[9:0]); end
            deliver();
        end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] r;
        logic         zf, ov, dz, seen;
        int           lat;
        op = 4'hD; operand_a = 32'h00010003; operand_b = 32'h5; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL abort_handshake got %b want 01", {out_valid, in_ready}); end
        total++; if (result !== '0) begin bad++; $display("FAIL abort_result got %h want 0", result); end
        seen = 1'b0;
        out_ready = 1'b1;
        repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
        out_ready = 1'b0;
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_delivery got %b want 0", seen); end
        run_op(4'h0, 32'd2, 32'd3, r, zf, ov, dz, lat);
        total++; if (r !== 32'd5) begin bad++; $display("FAIL abort_next_add got %h want 5", r); end
        total++; if (lat != 1) begin bad++; $display("FAIL abort_next_latency got %0d want 1", lat); end
        deliver();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
